// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill pixel engine with a start/busy/done handshake.
// A command is latched from IDLE, clipped to the screen, then walked in raster
// order with one registered pixel write per clock.
// Optional feature macro: VGA_RECT_OUTLINE_EN (border-only plotting).
module vga_rect_fill #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int XW      = 9,
  parameter int YW      = 8,
  parameter int COLOR_W = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [XW-1:0]      x0,
  input  logic [YW-1:0]      y0,
  input  logic [XW:0]        w,
  input  logic [YW:0]        h,
  input  logic [COLOR_W-1:0] color,
  input  logic               outline,
  output logic [XW-1:0]      VGA_X,
  output logic [YW-1:0]      VGA_Y,
  output logic [COLOR_W-1:0] VGA_COLOR,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  // Last on-screen column/row, widened so unclipped sums never wrap.
  localparam logic [XW+1:0] H_LAST = (XW+2)'(H_RES - 1);
  localparam logic [YW+1:0] V_LAST = (YW+2)'(V_RES - 1);

  state_t               state_q, state_d;
  logic [XW-1:0]        cx_q, cx_d;
  logic [YW-1:0]        cy_q, cy_d;
  logic [XW-1:0]        x0_q, x0_d;
  logic [YW-1:0]        y0_q, y0_d;
  logic [XW-1:0]        xend_q, xend_d;
  logic [YW-1:0]        yend_q, yend_d;
  logic [COLOR_W-1:0]   col_q, col_d;
  logic [XW-1:0]        vx_q, vx_d;
  logic [YW-1:0]        vy_q, vy_d;
  logic [COLOR_W-1:0]   vc_q, vc_d;
  logic                 plot_q, plot_d;
  logic                 done_q, done_d;

  logic [XW+1:0]        x_sum;
  logic [YW+1:0]        y_sum;
  logic [XW-1:0]        x_end_clip;
  logic [YW-1:0]        y_end_clip;
  logic                 degenerate;
  logic                 accept;
  logic                 pix_vld;
  logic                 pix_plot;

`ifdef VGA_RECT_OUTLINE_EN
  logic                 outl_q, outl_d;
  logic                 on_border;
`else
  logic                 unused_outline;
  assign unused_outline = outline;
`endif

  // Clip the incoming command against the screen and classify empty commands.
  always_comb begin
    x_sum      = {2'b00, x0} + {1'b0, w} - (XW+2)'(1);
    y_sum      = {2'b00, y0} + {1'b0, h} - (YW+2)'(1);
    x_end_clip = (x_sum > H_LAST) ? H_LAST[XW-1:0] : x_sum[XW-1:0];
    y_end_clip = (y_sum > V_LAST) ? V_LAST[YW-1:0] : y_sum[YW-1:0];
    degenerate = (w == '0) || (h == '0) ||
                 ({2'b00, x0} > H_LAST) || ({2'b00, y0} > V_LAST);
    // The done cycle still counts as busy, so start is refused there too.
    accept     = (state_q == S_IDLE) && start && !done_q;
  end

`ifdef VGA_RECT_OUTLINE_EN
  // Border test against the latched rectangle; interior pixels are skipped.
  always_comb begin
    on_border = (cx_q == x0_q) || (cx_q == xend_q) ||
                (cy_q == y0_q) || (cy_q == yend_q);
    pix_plot  = (state_q == S_DRAW) && (!outl_q || on_border);
  end
`else
  // Solid fill: every visited pixel is written.
  always_comb begin
    pix_plot = (state_q == S_DRAW);
  end
`endif

  // Next-state, raster scan counters and registered pixel outputs.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    xend_d  = xend_q;
    yend_d  = yend_q;
    col_d   = col_q;
`ifdef VGA_RECT_OUTLINE_EN
    outl_d  = outl_q;
`endif
    pix_vld = (state_q == S_DRAW);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x0_d   = x0;
          y0_d   = y0;
          xend_d = x_end_clip;
          yend_d = y_end_clip;
          col_d  = color;
`ifdef VGA_RECT_OUTLINE_EN
          outl_d = outline;
`endif
          if (degenerate) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAW;
            cx_d    = x0;
            cy_d    = y0;
          end
        end
      end
      S_DRAW: begin
        if (cx_q == xend_q) begin
          cx_d = x0_q;
          if (cy_q == yend_q) begin
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + YW'(1);
          end
        end else begin
          cx_d = cx_q + XW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Coordinates follow every scanned pixel and hold otherwise.
    vx_d   = pix_vld ? cx_q  : vx_q;
    vy_d   = pix_vld ? cy_q  : vy_q;
    vc_d   = pix_vld ? col_q : vc_q;
    plot_d = pix_plot;
    done_d = (state_q == S_DONE);
  end

  // State and datapath registers; reset abandons any rectangle in progress.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      xend_q  <= '0;
      yend_q  <= '0;
      col_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef VGA_RECT_OUTLINE_EN
      outl_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xend_q  <= xend_d;
      yend_q  <= yend_d;
      col_q   <= col_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
`ifdef VGA_RECT_OUTLINE_EN
      outl_q  <= outl_d;
`endif
    end
  end

  assign VGA_X     = vx_q;
  assign VGA_Y     = vy_q;
  assign VGA_COLOR = vc_q;
  assign plot      = plot_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill (default 320x240, 3-bit colour).
// Honours VGA_RECT_OUTLINE_EN to pick the expected outline behaviour.
module tb_vga_rect_fill;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] x0;
  logic [7:0] y0;
  logic [9:0] w;
  logic [8:0] h;
  logic [2:0] color;
  logic       outline;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_color;
  logic       plot;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  vga_rect_fill dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .outline  (outline),
    .VGA_X    (vga_x),
    .VGA_Y    (vga_y),
    .VGA_COLOR(vga_color),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Present one command for exactly one rising edge (edge N), return just after it.
  task automatic send_cmd(input logic [8:0] cx0, input logic [7:0] cy0,
                          input logic [9:0] cw, input logic [8:0] ch,
                          input logic [2:0] ccol, input logic coutl);
    @(negedge clk);
    x0 = cx0; y0 = cy0; w = cw; h = ch; color = ccol; outline = coutl;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0;
    color = '0; outline = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({plot, busy, done} !== 3'b000 || vga_x !== 9'd0 || vga_y !== 8'd0 || vga_color !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: plot/busy/done=%b x=%0d y=%0d c=%0d, required all zero",
               {plot, busy, done}, vga_x, vga_y, vga_color);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_solid;
    int ex[6] = '{10, 11, 12, 10, 11, 12};
    int ey[6] = '{20, 20, 20, 21, 21, 21};
    send_cmd(9'd10, 8'd20, 10'd3, 9'd2, 3'b100, 1'b0);
    @(negedge clk);
    total++;
    if (plot !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL solid_accept: plot=%b busy=%b, required plot=0 busy=1", plot, busy);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (plot !== 1'b1 || vga_x !== 9'(ex[i]) || vga_y !== 8'(ey[i]) || vga_color !== 3'b100) begin
        bad++;
        $display("FAIL solid_pix%0d: plot=%b (%0d,%0d) c=%b, required plot=1 (%0d,%0d) c=100",
                 i, plot, vga_x, vga_y, vga_color, ex[i], ey[i]);
      end
    end
    @(negedge clk);
    total++;
    if (plot !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL solid_done: plot=%b done=%b busy=%b, required 0 1 1", plot, done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0 || vga_x !== 9'd12 || vga_y !== 8'd21) begin
      bad++;
      $display("FAIL solid_after: done=%b busy=%b plot=%b (%0d,%0d), required 0 0 0 held (12,21)",
               done, busy, plot, vga_x, vga_y);
    end
  endtask

  task automatic test_clip;
    int ex[2] = '{318, 319};
    send_cmd(9'd318, 8'd239, 10'd5, 9'd4, 3'b011, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (plot !== 1'b1 || vga_x !== 9'(ex[i]) || vga_y !== 8'd239) begin
        bad++;
        $display("FAIL clip_pix%0d: plot=%b (%0d,%0d), required plot=1 (%0d,239)",
                 i, plot, vga_x, vga_y, ex[i]);
      end
    end
    @(negedge clk);
    total++;
    if (plot !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL clip_done: plot=%b done=%b, required plot=0 done=1", plot, done);
    end
    @(negedge clk);
  endtask

  task automatic test_degenerate;
    logic [8:0] dx[2] = '{9'd5, 9'd400};
    logic [9:0] dw[2] = '{10'd0, 10'd3};
    for (int r = 0; r < 2; r++) begin
      send_cmd(dx[r], 8'd5, dw[r], 9'd5, 3'b001, 1'b0);
      @(negedge clk);
      total++;
      if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL degen%0d_accept: plot=%b done=%b busy=%b, required 0 0 1", r, plot, done, busy);
      end
      @(negedge clk);
      total++;
      if (plot !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("FAIL degen%0d_done: plot=%b done=%b, required plot=0 done=1", r, plot, done);
      end
      @(negedge clk);
      total++;
      if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL degen%0d_after: plot=%b done=%b busy=%b, required 0 0 0", r, plot, done, busy);
      end
    end
  endtask

  // 4x4 fill with a rejected start during DRAW and another in the done cycle.
  task automatic test_back_to_back;
    int plots = 0;
    int dones = 0;
    int stray = 0;
    send_cmd(9'd0, 8'd0, 10'd4, 9'd4, 3'b010, 1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (plot === 1'b1) begin
        plots++;
        if (vga_x > 9'd3 || vga_y > 8'd3) stray++;
      end
      if (done === 1'b1) begin
        dones++;
        x0 = 9'd50; start = 1'b1;
      end
      if (c == 3) begin
        x0 = 9'd100; start = 1'b1;
      end
    end
    start = 1'b0;
    total++;
    if (plots != 16) begin
      bad++;
      $display("FAIL busy_plots: got %0d plots, required 16", plots);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL busy_dones: got %0d done pulses, required 1", dones);
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL busy_range: %0d plots outside x0..3/y0..3, required 0", stray);
    end
  endtask

  task automatic test_reset_mid;
    int plots = 0;
    send_cmd(9'd0, 8'd0, 10'd10, 9'd10, 3'b101, 1'b0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({plot, busy, done} !== 3'b000 || vga_x !== 9'd0 || vga_color !== 3'd0) begin
      bad++;
      $display("FAIL reset_async: plot/busy/done=%b x=%0d c=%0d, required all zero", {plot, busy, done}, vga_x, vga_color);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (plot === 1'b1 || busy === 1'b1) plots++;
    end
    total++;
    if (plots != 0) begin
      bad++;
      $display("FAIL reset_quiet: %0d active cycles after reset, required 0", plots);
    end
    send_cmd(9'd7, 8'd7, 10'd1, 9'd1, 3'b110, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (plot !== 1'b1 || vga_x !== 9'd7 || vga_y !== 8'd7 || vga_color !== 3'b110) begin
      bad++;
      $display("FAIL reset_new: plot=%b (%0d,%0d) c=%b, required plot=1 (7,7) c=110", plot, vga_x, vga_y, vga_color);
    end
    @(negedge clk);
    total++;
    if (plot !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL reset_new_done: plot=%b done=%b, required plot=0 done=1", plot, done);
    end
    @(negedge clk);
  endtask

  task automatic test_outline;
`ifdef VGA_RECT_OUTLINE_EN
    logic [11:0] exp_plot = 12'b1111_1001_1111;
`else
    logic [11:0] exp_plot = 12'b1111_1111_1111;
`endif
    int ex[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int ey[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    send_cmd(9'd0, 8'd0, 10'd4, 9'd3, 3'b111, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (plot !== exp_plot[11-i] || vga_x !== 9'(ex[i]) || vga_y !== 8'(ey[i]) || done !== 1'b0) begin
        bad++;
        $display("FAIL outline_scan%0d: plot=%b (%0d,%0d) done=%b, required plot=%b (%0d,%0d) done=0",
                 i, plot, vga_x, vga_y, done, exp_plot[11-i], ex[i], ey[i]);
      end
    end
    @(negedge clk);
    total++;
    if (plot !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL outline_done: plot=%b done=%b, required plot=0 done=1", plot, done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_solid;
    test_clip;
    test_degenerate;
    test_back_to_back;
    test_reset_mid;
    test_outline;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
